// File: rtl/nn_host_bridge.sv
// Byte-stream host bridge: decodes write/read commands from an rx byte stream into
// accelerator memory-map write strobes and output-memory reads streamed back on tx.
module nn_host_bridge #(
    parameter int MM_DEPTH     = 16,
    parameter int MM_SIZE      = 32,
    parameter int Q_SIZE       = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_valid,
    output logic                rx_ready,
    input  logic [7:0]          rx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [7:0]          tx_data,
    output logic                nn_write_enable,
    input  logic                nn_busy,
    output logic [MM_DEPTH-1:0] nn_write_addr,
    output logic [MM_SIZE-1:0]  nn_write_data,
    output logic [MM_DEPTH-1:0] nn_read_addr,
    input  logic [Q_SIZE-1:0]   nn_read_data,
    output logic                cmd_error
);

    localparam int A_BYTES   = MM_DEPTH / 8;
    localparam int D_BYTES   = MM_SIZE / 8;
    localparam int Q_BYTES   = Q_SIZE / 8;
    localparam int MAX_AD    = (A_BYTES > D_BYTES) ? A_BYTES : D_BYTES;
    localparam int MAX_BYTES = (MAX_AD > Q_BYTES) ? MAX_AD : Q_BYTES;
    localparam int CNT_W     = $clog2(MAX_BYTES + 1);

    localparam logic [CNT_W-1:0] A_LAST  = CNT_W'(A_BYTES - 1);
    localparam logic [CNT_W-1:0] D_LAST  = CNT_W'(D_BYTES - 1);
    localparam logic [CNT_W-1:0] Q_LAST  = CNT_W'(Q_BYTES - 1);
    localparam logic [1:0]       RL_LAST = 2'(READ_LATENCY - 1);

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_WRITE,
        S_RD_WAIT,
        S_TX
    } state_t;

    state_t              state_q, state_d;
    logic                is_write_q, is_write_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          rd_cnt_q, rd_cnt_d;
    logic [MM_DEPTH-1:0] addr_q, addr_d;
    logic [MM_SIZE-1:0]  data_q, data_d;
    logic [Q_SIZE-1:0]   tx_shift_q, tx_shift_d;
    logic                cmd_error_q, cmd_error_d;

    always_comb begin
        state_d     = state_q;
        is_write_d  = is_write_q;
        cnt_d       = cnt_q;
        rd_cnt_d    = rd_cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        tx_shift_d  = tx_shift_q;
        cmd_error_d = cmd_error_q;

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    cnt_d = '0;
                    if (rx_data == OP_WRITE) begin
                        is_write_d = 1'b1;
                        state_d    = S_ADDR;
                    end else if (rx_data == OP_READ) begin
                        is_write_d = 1'b0;
                        state_d    = S_ADDR;
                    end else begin
                        cmd_error_d = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    addr_d = (addr_q << 8) | MM_DEPTH'(rx_data);
                    if (cnt_q == A_LAST) begin
                        cnt_d    = '0;
                        rd_cnt_d = '0;
                        state_d  = is_write_q ? S_DATA : S_RD_WAIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    data_d = (data_q << 8) | MM_SIZE'(rx_data);
                    if (cnt_q == D_LAST) begin
                        cnt_d   = '0;
                        state_d = S_WRITE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_WRITE: begin
                // The strobe itself is decoded combinationally so it can fire
                // in the same cycle nn_busy drops.
                if (!nn_busy) begin
                    state_d = S_IDLE;
                end
            end
            S_RD_WAIT: begin
                if (rd_cnt_q == RL_LAST) begin
                    tx_shift_d = nn_read_data;
                    cnt_d      = '0;
                    rd_cnt_d   = '0;
                    state_d    = S_TX;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            S_TX: begin
                if (tx_ready) begin
                    tx_shift_d = tx_shift_q << 8;
                    if (cnt_q == Q_LAST) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            is_write_q  <= 1'b0;
            cnt_q       <= '0;
            rd_cnt_q    <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            tx_shift_q  <= '0;
            cmd_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_write_q  <= is_write_d;
            cnt_q       <= cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            tx_shift_q  <= tx_shift_d;
            cmd_error_q <= cmd_error_d;
        end
    end

    assign rx_ready        = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_DATA);
    assign tx_valid        = (state_q == S_TX);
    assign tx_data         = tx_shift_q[Q_SIZE-1 -: 8];
    assign nn_write_enable = (state_q == S_WRITE) && !nn_busy;
    assign nn_write_addr   = addr_q;
    assign nn_write_data   = data_q;
    assign nn_read_addr    = addr_q;
    assign cmd_error       = cmd_error_q;

endmodule

// File: tb/tb_nn_host_bridge.sv
// Directed bench for nn_host_bridge: write, busy stall, reads, bad opcode,
// mid-command reset and back-to-back write spacing.
module tb_nn_host_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        nn_write_enable;
    logic        nn_busy = 1'b0;
    logic [15:0] nn_write_addr;
    logic [31:0] nn_write_data;
    logic [15:0] nn_read_addr;
    logic [15:0] nn_read_data;
    logic        cmd_error;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_acc = 0;

    int          strobes = 0;
    logic [15:0] s_addr[32];
    logic [31:0] s_data[32];
    int          s_cyc[32];

    logic [7:0] got[4];
    int         ngot;
    int         holdviol;

    nn_host_bridge #(
        .MM_DEPTH(16), .MM_SIZE(32), .Q_SIZE(16), .READ_LATENCY(1)
    ) dut (
        .clk(clk), .reset(reset),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .nn_write_enable(nn_write_enable), .nn_busy(nn_busy),
        .nn_write_addr(nn_write_addr), .nn_write_data(nn_write_data),
        .nn_read_addr(nn_read_addr), .nn_read_data(nn_read_data),
        .cmd_error(cmd_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output-memory model: data valid in the cycle the address is presented.
    assign nn_read_data = (nn_read_addr == 16'h0003) ? 16'hBEEF : (nn_read_addr ^ 16'h5A5A);

    always @(negedge clk) begin
        if (nn_write_enable === 1'b1) begin
            if (strobes < 32) begin
                s_addr[strobes] = nn_write_addr;
                s_data[strobes] = nn_write_data;
                s_cyc[strobes]  = cyc;
            end
            strobes = strobes + 1;
            $display("strobe cyc=%0d addr=%h data=%h", cyc, nn_write_addr, nn_write_data);
        end
    end

    // Presents one byte and returns at posedge+1 after it is accepted; leaves rx_valid high.
    task automatic send_byte(input logic [7:0] b);
        bit done = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (rx_ready) done = 1;
            @(posedge clk);
            #1;
        end
        last_acc = cyc;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL send_timeout byte=%h accepted=0 required=1", b);
        end
    endtask

    task automatic send_write(input logic [15:0] a, input logic [31:0] d);
        send_byte(8'h57);
        send_byte(a[15:8]); send_byte(a[7:0]);
        send_byte(d[31:24]); send_byte(d[23:16]); send_byte(d[15:8]); send_byte(d[7:0]);
        $display("write cmd addr=%h data=%h", a, d);
    endtask

    task automatic send_read(input logic [15:0] a);
        send_byte(8'h52);
        send_byte(a[15:8]); send_byte(a[7:0]);
        rx_valid = 1'b0;
        $display("read cmd addr=%h", a);
    endtask

    task automatic recv_bytes(input int n, input bit toggle);
        bit          hold_pending = 0;
        logic [7:0]  hold_byte = 8'h00;
        ngot = 0;
        holdviol = 0;
        for (int it = 0; it < 64 && ngot < n; it++) begin
            tx_ready = toggle ? it[0] : 1'b1;
            @(negedge clk);
            if (tx_valid && tx_ready) begin
                if (hold_pending && tx_data !== hold_byte) holdviol++;
                hold_pending = 0;
                got[ngot] = tx_data;
                ngot++;
            end else if (tx_valid) begin
                if (hold_pending && tx_data !== hold_byte) holdviol++;
                hold_pending = 1;
                hold_byte    = tx_data;
            end
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b0;
        total++;
        if (ngot != n) begin
            bad++;
            $display("FAIL recv_timeout got=%0d required=%0d", ngot, n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL rst_rx_ready got=%b exp=1", rx_ready); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid got=%b exp=0", tx_valid); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
        total++; if (nn_write_enable !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", nn_write_enable); end
        total++; if (nn_write_addr !== 16'h0) begin bad++; $display("FAIL rst_waddr got=%h exp=0", nn_write_addr); end
        total++; if (nn_write_data !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", nn_write_data); end
        total++; if (nn_read_addr !== 16'h0) begin bad++; $display("FAIL rst_raddr got=%h exp=0", nn_read_addr); end
        total++; if (cmd_error !== 1'b0) begin bad++; $display("FAIL rst_cmd_error got=%b exp=0", cmd_error); end
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        int s0 = strobes;
        int c;
        send_write(16'h4000, 32'h12345678);
        rx_valid = 1'b0;
        c = last_acc;
        @(negedge clk);
        @(negedge clk);
        total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL wr_rx_ready_after got=%b exp=1", rx_ready); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (strobes - s0 !== 1) begin bad++; $display("FAIL wr_strobe_count got=%0d exp=1", strobes - s0); end
        total++; if (s_cyc[s0] !== c) begin bad++; $display("FAIL wr_strobe_cycle got=%0d exp=%0d", s_cyc[s0], c); end
        total++; if (s_addr[s0] !== 16'h4000) begin bad++; $display("FAIL wr_addr got=%h exp=4000", s_addr[s0]); end
        total++; if (s_data[s0] !== 32'h12345678) begin bad++; $display("FAIL wr_data got=%h exp=12345678", s_data[s0]); end
    endtask

    task automatic test_busy_stall();
        int s0 = strobes;
        int c;
        send_byte(8'h57); send_byte(8'h40); send_byte(8'h00);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        nn_busy = 1'b1;
        send_byte(8'h78);
        rx_valid = 1'b0;
        c = last_acc;
        repeat (4) @(posedge clk);
        #1;
        nn_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("busy write addr=4000 data=12345678");
        total++; if (strobes - s0 !== 1) begin bad++; $display("FAIL busy_strobe_count got=%0d exp=1", strobes - s0); end
        total++; if (s_cyc[s0] !== c + 4) begin bad++; $display("FAIL busy_strobe_cycle got=%0d exp=%0d", s_cyc[s0], c + 4); end
        total++; if (s_addr[s0] !== 16'h4000) begin bad++; $display("FAIL busy_addr got=%h exp=4000", s_addr[s0]); end
        total++; if (s_data[s0] !== 32'h12345678) begin bad++; $display("FAIL busy_data got=%h exp=12345678", s_data[s0]); end
    endtask

    task automatic test_read();
        send_read(16'h0003);
        @(negedge clk);
        total++; if (nn_read_addr !== 16'h0003) begin bad++; $display("FAIL rd_addr got=%h exp=0003", nn_read_addr); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rd_tx_early got=%b exp=0", tx_valid); end
        @(negedge clk);
        total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL rd_tx_rise got=%b exp=1", tx_valid); end
        @(posedge clk); #1;
        recv_bytes(2, 1'b0);
        total++; if (got[0] !== 8'hBE) begin bad++; $display("FAIL rd_byte0 got=%h exp=BE", got[0]); end
        total++; if (got[1] !== 8'hEF) begin bad++; $display("FAIL rd_byte1 got=%h exp=EF", got[1]); end
        @(negedge clk);
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rd_tx_done got=%b exp=0", tx_valid); end
        @(posedge clk); #1;

        send_read(16'h0003);
        recv_bytes(2, 1'b1);
        total++; if (got[0] !== 8'hBE) begin bad++; $display("FAIL rdt_byte0 got=%h exp=BE", got[0]); end
        total++; if (got[1] !== 8'hEF) begin bad++; $display("FAIL rdt_byte1 got=%h exp=EF", got[1]); end
        total++; if (holdviol !== 0) begin bad++; $display("FAIL rdt_hold got=%0d exp=0", holdviol); end
        @(negedge clk);
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rdt_no_dup got=%b exp=0", tx_valid); end
        @(posedge clk); #1;

        send_read(16'h0102);
        recv_bytes(2, 1'b0);
        total++; if (got[0] !== 8'h5B) begin bad++; $display("FAIL rd2_byte0 got=%h exp=5B", got[0]); end
        total++; if (got[1] !== 8'h58) begin bad++; $display("FAIL rd2_byte1 got=%h exp=58", got[1]); end
    endtask

    task automatic test_bad_opcode();
        int s0 = strobes;
        send_byte(8'hAA);
        send_write(16'h0020, 32'hCAFEBABE);
        rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        total++; if (cmd_error !== 1'b1) begin bad++; $display("FAIL bad_cmd_error got=%b exp=1", cmd_error); end
        total++; if (strobes - s0 !== 1) begin bad++; $display("FAIL bad_strobe_count got=%0d exp=1", strobes - s0); end
        total++; if (s_addr[s0] !== 16'h0020) begin bad++; $display("FAIL bad_addr got=%h exp=0020", s_addr[s0]); end
        total++; if (s_data[s0] !== 32'hCAFEBABE) begin bad++; $display("FAIL bad_data got=%h exp=CAFEBABE", s_data[s0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int s0 = strobes;
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h01);
        rx_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        $display("reset mid-command");
        total++; if (strobes !== s0) begin bad++; $display("FAIL rstmid_no_strobe got=%0d exp=%0d", strobes, s0); end
        total++; if (cmd_error !== 1'b0) begin bad++; $display("FAIL rstmid_cmd_error got=%b exp=0", cmd_error); end
        send_write(16'h0001, 32'h00000009);
        rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (strobes - s0 !== 1) begin bad++; $display("FAIL rstmid_strobe_count got=%0d exp=1", strobes - s0); end
        total++; if (s_addr[s0] !== 16'h0001) begin bad++; $display("FAIL rstmid_addr got=%h exp=0001", s_addr[s0]); end
        total++; if (s_data[s0] !== 32'h00000009) begin bad++; $display("FAIL rstmid_data got=%h exp=00000009", s_data[s0]); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] va[4];
        logic [31:0] vd[4];
        int s0 = strobes;
        va[0] = 16'h1000; vd[0] = 32'h11111111;
        va[1] = 16'h2001; vd[1] = 32'h22223333;
        va[2] = 16'h3002; vd[2] = 32'hDEADBEEF;
        va[3] = 16'hFFFF; vd[3] = 32'h00000001;
        for (int i = 0; i < 4; i++) send_write(va[i], vd[i]);
        rx_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total++; if (strobes - s0 !== 4) begin bad++; $display("FAIL b2b_strobe_count got=%0d exp=4", strobes - s0); end
        for (int i = 0; i < 4; i++) begin
            total++; if (s_addr[s0+i] !== va[i]) begin bad++; $display("FAIL b2b_addr%0d got=%h exp=%h", i, s_addr[s0+i], va[i]); end
            total++; if (s_data[s0+i] !== vd[i]) begin bad++; $display("FAIL b2b_data%0d got=%h exp=%h", i, s_data[s0+i], vd[i]); end
        end
        for (int i = 1; i < 4; i++) begin
            total++;
            if (s_cyc[s0+i] - s_cyc[s0+i-1] !== 8) begin
                bad++;
                $display("FAIL b2b_spacing%0d got=%0d exp=8", i, s_cyc[s0+i] - s_cyc[s0+i-1]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_write();
        test_busy_stall();
        test_read();
        test_bad_opcode();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
